// File: rtl/axi_stream_fifo.sv
// axi_stream_fifo: synchronous valid/ready FIFO with occupancy count, watermarks and flush
//   clk, reset (sync, active-high), flush (sync clear)
//   wdata/wvalid/wready : write side, wready = !full
//   rdata/rvalid/rready : read side, first-word fall-through, rvalid = count != 0
//   count, full, empty, almost_full, almost_empty : decodes of the count register
//   err_sticky[1:0] (only with AXI_FIFO_ERR_EN): bit0 overflow attempt, bit1 underflow attempt
module axi_stream_fifo #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef AXI_FIFO_ERR_EN
    output logic [1:0]                 err_sticky,
`endif
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_fire, rd_fire;

    assign count        = count_q;
    assign full         = count_q == CW'(DEPTH);
    assign empty        = count_q == '0;
    assign wready       = !full;
    assign rvalid       = !empty;
    assign almost_full  = count_q >= CW'(AF_THRESH);
    assign almost_empty = count_q <= CW'(AE_THRESH);
    assign rdata        = mem_q[rptr_q];

    // Flush wins over both handshakes; the word offered in a flush cycle is dropped.
    always_comb begin
        wr_fire = wvalid && wready && !flush;
        rd_fire = rready && rvalid && !flush;
        wptr_d  = flush ? '0 : wptr_q + AW'(wr_fire);
        rptr_d  = flush ? '0 : rptr_q + AW'(rd_fire);
        count_d = flush ? '0 : count_q + CW'(wr_fire) - CW'(rd_fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wptr_q] <= wdata;
    end

`ifdef AXI_FIFO_ERR_EN
    logic [1:0] err_q, err_d;

    assign err_sticky = err_q;

    always_comb err_d = flush ? 2'b00 : err_q | {rready && empty, wvalid && full};

    always_ff @(posedge clk) begin
        if (reset) err_q <= 2'b00;
        else       err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_axi_stream_fifo.sv
// tb_axi_stream_fifo: scoreboard bench for axi_stream_fifo (DEPTH=8, DATA_W=10, AF=6, AE=1)
module tb_axi_stream_fifo;
    logic       clk = 0, reset = 1, flush = 0, wvalid = 0, rready = 0;
    logic [9:0] wdata = '0;
    logic [9:0] rdata;
    logic [3:0] count;
    logic       wready, rvalid, full, empty, almost_full, almost_empty;
`ifdef AXI_FIFO_ERR_EN
    logic [1:0] err_sticky;
`endif
    int         compared = 0, mismatched = 0;
    logic [9:0] sb[$];
    wire  [9:0] stat = {count, full, empty, rvalid, wready, almost_full, almost_empty};

    axi_stream_fifo dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .count(count),
`ifdef AXI_FIFO_ERR_EN
        .err_sticky(err_sticky),
`endif
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required summary before %0t", $time);
        $fatal(1);
    end

    function automatic logic [9:0] exp_status(input int n);
        return {4'(n), n == 8, n == 0, n != 0, n != 8, n >= 6, n <= 1};
    endfunction

    // One clock of stimulus; inputs are changed #1 after the rising edge.
    // Writes push to the scoreboard, reads pop and compare the head word.
    task automatic cycle(input logic w, input logic [9:0] d, input logic r, input logic f);
        logic wf, rf;
        wvalid = w; wdata = d; rready = r; flush = f;
        #1;
        wf = w && sb.size() < 8;
        rf = r && sb.size() > 0;
        if (f) sb.delete();
        else begin
            if (rf) begin
                compared++;
                if (rdata !== sb[0]) begin
                    mismatched++;
                    $display("FAIL read_data: got %h want %h", rdata, sb[0]);
                end
                void'(sb.pop_front());
            end
            if (wf) sb.push_back(d);
        end
        @(posedge clk); #1;
        wvalid = 0; rready = 0; flush = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (stat !== exp_status(0)) begin
            mismatched++;
            $display("FAIL reset_status: got %b want %b", stat, exp_status(0));
        end
        cycle(1, 10'h011, 0, 0);
        cycle(1, 10'h022, 0, 0);
        do_reset();
        compared++;
        if (stat !== exp_status(0)) begin
            mismatched++;
            $display("FAIL reset_midop_status: got %b want %b", stat, exp_status(0));
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 10'(i), 0, 0);
            compared++;
            if (stat !== exp_status(i)) begin
                mismatched++;
                $display("FAIL fill_status[%0d]: got %b want %b", i, stat, exp_status(i));
            end
        end
        cycle(1, 10'h3FF, 0, 0);
        compared++;
        if (count !== 4'd8 || wready !== 1'b0) begin
            mismatched++;
            $display("FAIL overflow_ignored: count %0d wready %b want 8 0", count, wready);
        end
        for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0);
        compared++;
        if (stat !== exp_status(0)) begin
            mismatched++;
            $display("FAIL drain_status: got %b want %b", stat, exp_status(0));
        end
        cycle(0, '0, 1, 0);
        compared++;
        if (count !== 4'd0) begin
            mismatched++;
            $display("FAIL underflow_ignored: count %0d want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) cycle(1, 10'h100 + 10'(i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 10'h200 + 10'(i), 1, 0);
            compared++;
            if (count !== 4'd3) begin
                mismatched++;
                $display("FAIL b2b_count[%0d]: got %0d want 3", i, count);
            end
        end
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
        compared++;
        if (stat !== exp_status(0)) begin
            mismatched++;
            $display("FAIL b2b_drain: got %b want %b", stat, exp_status(0));
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) cycle(1, 10'h0A0 + 10'(i), 0, 0);
        cycle(1, 10'h2AA, 1, 0);
        compared++;
        if (count !== 4'd7 || full !== 1'b0) begin
            mismatched++;
            $display("FAIL full_rw_count: count %0d full %b want 7 0", count, full);
        end
        cycle(1, 10'h2AA, 0, 0);
        compared++;
        if (count !== 4'd8 || full !== 1'b1) begin
            mismatched++;
            $display("FAIL full_rw_refill: count %0d full %b want 8 1", count, full);
        end
        for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0);
        compared++;
        if (count !== 4'd0) begin
            mismatched++;
            $display("FAIL full_rw_drain: count %0d want 0", count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle(1, 10'h050 + 10'(i), 0, 0);
        cycle(1, 10'h123, 1, 1);
        compared++;
        if (stat !== exp_status(0)) begin
            mismatched++;
            $display("FAIL flush_status: got %b want %b", stat, exp_status(0));
        end
        cycle(1, 10'h155, 0, 0);
        compared++;
        if (rvalid !== 1'b1 || rdata !== 10'h155 || count !== 4'd1) begin
            mismatched++;
            $display("FAIL flush_then_write: rvalid %b rdata %h count %0d want 1 155 1", rvalid, rdata, count);
        end
        cycle(0, '0, 1, 0);
    endtask

`ifdef AXI_FIFO_ERR_EN
    task automatic test_err();
        do_reset();
        compared++;
        if (err_sticky !== 2'b00) begin
            mismatched++;
            $display("FAIL err_reset: got %b want 00", err_sticky);
        end
        for (int i = 0; i < 8; i++) cycle(1, 10'(i), 0, 0);
        cycle(1, 10'h3FF, 0, 0);
        compared++;
        if (err_sticky !== 2'b01) begin
            mismatched++;
            $display("FAIL err_overflow: got %b want 01", err_sticky);
        end
        for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0);
        cycle(0, '0, 1, 0);
        compared++;
        if (err_sticky !== 2'b11) begin
            mismatched++;
            $display("FAIL err_underflow: got %b want 11", err_sticky);
        end
        cycle(0, '0, 0, 1);
        compared++;
        if (err_sticky !== 2'b00) begin
            mismatched++;
            $display("FAIL err_flush: got %b want 00", err_sticky);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_rw();
        test_flush();
`ifdef AXI_FIFO_ERR_EN
        test_err();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
